pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline register.
- Generic stage register placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake and a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Supports synchronous flush, bubble zeroing of control/data fields, and a "keep" field (e.g. PC+8) that survives bubbles.

Parameters:
- CTRL_W, 32, width of control bundle; zeroed whenever the output is a bubble.
- DATA_W, 96, width of data bundle (operands, immediate, register indices); zeroed whenever the output is a bubble.
- KEEP_W, 32, width of preserved field (PC+8); never zeroed on bubble or flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  block can accept an entry this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  data bundle.
- in_keep  in  KEEP_W  preserved field.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the output entry.
- out_ctrl  out  CTRL_W  control bundle.
- out_data  out  DATA_W  data bundle.
- out_keep  out  KEEP_W  preserved field.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - Main register (drives the outputs) plus one skid register.
  - State is EMPTY(0), ONE(1) or FULL(2); occupancy is the state encoding.
- Reset (rst_n low, asynchronous):
  - State = EMPTY; out_valid = 0.
  - out_ctrl, out_data, out_keep and the skid contents = 0.
  - occupancy = 0.
- in_ready = (state != FULL):
  - Derived from registered state only; no combinational path from out_ready.
  - 1 from the first cycle after reset.
- out_valid = (state != EMPTY).
- Bubble zeroing: when out_valid = 0, out_ctrl = 0 and out_data = 0 are guaranteed.
- Transitions (flush = 0):
  - EMPTY, in_fire: main <= input, go to ONE. Latency is 1 cycle from in_fire to out_valid.
  - ONE, in_fire & out_fire: main <= input, stay ONE. Throughput is 1 entry per cycle.
  - ONE, in_fire & !out_fire: skid <= input, go to FULL.
  - ONE, !in_fire & out_fire: main ctrl/data <= 0, out_keep holds its value, go to EMPTY.
  - FULL, out_fire: main <= skid, go to ONE. in_fire cannot occur in FULL.
  - Any state, no fire: all contents hold.
- Ordering: entries leave strictly in acceptance order. No entry is lost or duplicated.
- Flush (synchronous; priority over all transitions):
  - State = EMPTY; main and skid ctrl/data <= 0.
  - out_keep <= in_keep (the PC is preserved through a bubble).
  - A concurrent in_fire is discarded.
  - A concurrent out_fire still counts as consumed by downstream.
- Reset asserted mid-operation: all entries are discarded immediately, regardless of clk.
- Widths: all fields are copied bit-exact; there is no arithmetic on the payload.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt [31:0]: increments each cycle with in_valid & !in_ready.
  - bubble_cnt [31:0]: increments each cycle with out_ready & !out_valid.
- Both counters saturate at 0xFFFFFFFF, reset to 0 on rst_n, and are unaffected by flush.
- When not defined, neither port nor counter logic exists. Core behaviour is identical either way.

Test Plan:
- Reset then stream: assert in_valid with ctrl = 1, 2, 3, 4 on consecutive cycles, out_ready = 1 -> out_valid rises 1 cycle after the first in_fire; out_ctrl reads 1, 2, 3, 4 on consecutive cycles; occupancy = 1 throughout; in_ready = 1 throughout.
- Back-pressure: out_ready = 0 while sending ctrl = 0xA, then 0xB -> occupancy reaches 2 and in_ready = 0. Release out_ready -> output 0xA then 0xB with no loss; occupancy returns to 0.
- Bubble: send one entry with keep = 0x400008, drain it, then idle -> out_valid = 0; out_ctrl = 0 and out_data = 0; out_keep = 0x400008.
- Flush when FULL with in_keep = 0x1000: assert flush for 1 cycle -> next cycle occupancy = 0, out_valid = 0, out_keep = 0x1000; the skid entry never appears at the output.
- Async reset: drop rst_n between clock edges while FULL -> outputs and occupancy go to 0 immediately. After release, in_ready = 1.
- PIPE_STAGE_PERF_EN build: hold in_valid = 1 and out_ready = 0 for 10 cycles from EMPTY -> stall_cnt = 8 (the first 2 entries are accepted); bubble_cnt = 0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt / bubble_cnt performance counters.
module pipe_stage_buf #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 96,
  parameter int KEEP_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              vld_p0;
  logic              in_fire;
  logic              out_fire;

  logic              load_main_in;
  logic              load_skid_in;
  logic              load_main_skid;
  logic              clear_main;

  logic [CTRL_W-1:0] main_ctrl_p0;
  logic [DATA_W-1:0] main_data_p0;
  logic [KEEP_W-1:0] main_keep_p0;
  logic [CTRL_W-1:0] skid_ctrl_p0;
  logic [DATA_W-1:0] skid_data_p0;
  logic [KEEP_W-1:0] skid_keep_p0;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p0 & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (in_fire) state_nxt = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_nxt = FULL;
          else if (!in_fire && out_fire) state_nxt = EMPTY;
        end
        FULL:  if (out_fire) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs come from registered state only, so out_ready never reaches in_ready.
  always_comb begin
    vld_p0    = (state != EMPTY);
    in_ready  = (state != FULL);
    occupancy = state;
  end

  assign out_valid = vld_p0;

  always_comb begin
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    clear_main     = 1'b0;
    if (!flush) begin
      unique case (state)
        EMPTY: load_main_in = in_fire;
        ONE: begin
          load_main_in = in_fire & out_fire;
          load_skid_in = in_fire & ~out_fire;
          clear_main   = ~in_fire & out_fire;
        end
        FULL:  load_main_skid = out_fire;
        default: ;
      endcase
    end
  end

  // ---- stage p0: main register, drives the outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl_p0 <= '0;
      main_data_p0 <= '0;
      main_keep_p0 <= '0;
    end else if (flush) begin
      main_ctrl_p0 <= '0;
      main_data_p0 <= '0;
      main_keep_p0 <= in_keep;
    end else if (load_main_in) begin
      main_ctrl_p0 <= in_ctrl;
      main_data_p0 <= in_data;
      main_keep_p0 <= in_keep;
    end else if (load_main_skid) begin
      main_ctrl_p0 <= skid_ctrl_p0;
      main_data_p0 <= skid_data_p0;
      main_keep_p0 <= skid_keep_p0;
    end else if (clear_main) begin
      // Draining to a bubble: the keep field stays so the PC remains visible.
      main_ctrl_p0 <= '0;
      main_data_p0 <= '0;
    end
  end

  // ---- stage p0: skid register, catches the entry accepted while stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      skid_keep_p0 <= '0;
    end else if (flush) begin
      skid_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
    end else if (load_skid_in) begin
      skid_ctrl_p0 <= in_ctrl;
      skid_data_p0 <= in_data;
      skid_keep_p0 <= in_keep;
    end
  end

  assign out_ctrl = main_ctrl_p0;
  assign out_data = main_data_p0;
  assign out_keep = main_keep_p0;

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_valid && !in_ready)  stall_cnt  <= sat_inc(stall_cnt);
      if (out_ready && !vld_p0)   bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf with a queue scoreboard checking order, payload and occupancy.
module tb_pipe_stage_buf;
  localparam int CTRL_W = 32;
  localparam int DATA_W = 96;
  localparam int KEEP_W = 32;
  localparam int ENT_W  = CTRL_W + DATA_W + KEEP_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [KEEP_W-1:0] in_keep;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
  logic [31:0]       stall_0, bubble_0;
`endif

  int tests = 0;
  int fails = 0;
  logic [ENT_W-1:0] sb_q[$];

  pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_keep(in_keep),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_keep(out_keep),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ENT_W-1:0] obs, input logic [ENT_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      check("occupancy", ENT_W'(occupancy), ENT_W'(sb_q.size()));
      check("out_valid", ENT_W'(out_valid), ENT_W'(sb_q.size() != 0));
      check("in_ready", ENT_W'(in_ready), ENT_W'(sb_q.size() != 2));
      if (!out_valid) check("bubble_zero", ENT_W'({out_ctrl, out_data}), '0);
      if (out_valid && out_ready) begin
        if (sb_q.size() != 0) begin
          check("sb_entry", {out_ctrl, out_data, out_keep}, sb_q.pop_front());
        end else begin
          tests++;
          fails++;
          $error("FAIL sb_underflow observed=output entry expected=none");
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data, in_keep});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [KEEP_W-1:0] k);
    in_valid = v;
    in_ctrl  = c;
    in_data  = {$urandom, $urandom, $urandom};
    in_keep  = k;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    check("rst_occ", ENT_W'(occupancy), 0);
    check("rst_valid", ENT_W'(out_valid), 0);
    check("rst_ctrl", ENT_W'(out_ctrl), 0);
    check("rst_keep", ENT_W'(out_keep), 0);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", ENT_W'(in_ready), 1);

    // Stream 1..4 at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CTRL_W'(i), KEEP_W'(32'h100 + i));
      tick();
      check("stream_valid", ENT_W'(out_valid), 1);
      check("stream_ctrl", ENT_W'(out_ctrl), ENT_W'(i));
      check("stream_occ", ENT_W'(occupancy), 1);
      check("stream_in_ready", ENT_W'(in_ready), 1);
    end
    drive(1'b0, '0, '0);
    tick();
    check("stream_drained", ENT_W'(occupancy), 0);

    // Back-pressure into the skid register
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h200);
    tick();
    check("bp_occ1", ENT_W'(occupancy), 1);
    drive(1'b1, 32'hB, 32'h204);
    tick();
    check("bp_occ2", ENT_W'(occupancy), 2);
    check("bp_in_ready", ENT_W'(in_ready), 0);
    check("bp_head", ENT_W'(out_ctrl), 32'hA);
    drive(1'b1, 32'hBAD, 32'h208);
    tick();
    check("bp_hold", ENT_W'(out_ctrl), 32'hA);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    check("bp_second", ENT_W'(out_ctrl), 32'hB);
    check("bp_occ_back1", ENT_W'(occupancy), 1);
    tick();
    check("bp_empty", ENT_W'(occupancy), 0);

    // Bubble keeps the PC field
    drive(1'b1, 32'h5, 32'h400008);
    tick();
    check("bub_keep_live", ENT_W'(out_keep), 32'h400008);
    drive(1'b0, '0, '0);
    tick();
    check("bub_valid", ENT_W'(out_valid), 0);
    check("bub_ctrl", ENT_W'(out_ctrl), 0);
    check("bub_data", ENT_W'(out_data), 0);
    check("bub_keep", ENT_W'(out_keep), 32'h400008);
    tick();
    check("bub_keep_idle", ENT_W'(out_keep), 32'h400008);

    // Flush while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'hC, 32'h300);
    tick();
    drive(1'b1, 32'hD, 32'h304);
    tick();
    check("fl_full", ENT_W'(occupancy), 2);
    drive(1'b1, 32'hE, 32'h1000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("fl_occ", ENT_W'(occupancy), 0);
    check("fl_valid", ENT_W'(out_valid), 0);
    check("fl_keep", ENT_W'(out_keep), 32'h1000);
    check("fl_ctrl", ENT_W'(out_ctrl), 0);
    out_ready = 1'b1;
    tick();
    check("fl_no_skid", ENT_W'(out_valid), 0);

    // Flush in ONE with concurrent in_fire and out_fire
    drive(1'b1, 32'h6, 32'h500);
    tick();
    drive(1'b1, 32'h7, 32'h2000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("fl1_occ", ENT_W'(occupancy), 0);
    check("fl1_keep", ENT_W'(out_keep), 32'h2000);
    tick();
    check("fl1_idle", ENT_W'(out_valid), 0);

    // Asynchronous reset while FULL, between clock edges
    out_ready = 1'b0;
    drive(1'b1, 32'h8, 32'h600);
    tick();
    drive(1'b1, 32'h9, 32'h604);
    tick();
    drive(1'b0, '0, '0);
    check("ar_full", ENT_W'(occupancy), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_occ", ENT_W'(occupancy), 0);
    check("ar_valid", ENT_W'(out_valid), 0);
    check("ar_ctrl", ENT_W'(out_ctrl), 0);
    check("ar_data", ENT_W'(out_data), 0);
    check("ar_keep", ENT_W'(out_keep), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_in_ready", ENT_W'(in_ready), 1);
    out_ready = 1'b1;
    drive(1'b1, 32'hF, 32'h700);
    tick();
    check("ar_resume", ENT_W'(out_ctrl), 32'hF);
    drive(1'b0, '0, '0);
    tick();
    check("ar_drained", ENT_W'(occupancy), 0);

`ifdef PIPE_STAGE_PERF_EN
    stall_0  = stall_cnt;
    bubble_0 = bubble_cnt;
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h800);
    repeat (10) tick();
    drive(1'b0, '0, '0);
    check("perf_stall", ENT_W'(stall_cnt - stall_0), 8);
    check("perf_bubble", ENT_W'(bubble_cnt - bubble_0), 0);
    out_ready = 1'b1;
    repeat (3) tick();
`endif

    out_ready = 1'b1;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
